// File: rtl/bk_kbd_pkg.sv
// Shared constants and frame FSM encoding for the PS/2 scancode decoder.
package bk_kbd_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [2:0] E1_SKIP   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a saturating-count glitch filter.
// The filtered line idles high, matching an undriven PS/2 bus.
module ps2_line_filter #(
  parameter int FILTER = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw,
  output logic line
);

  localparam int CW = (FILTER < 2) ? 1 : $clog2(FILTER + 1);

  logic sync_p0;
  logic sync_p1;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clk_sys domain.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Flip the output only after FILTER consecutive samples disagree with it.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      line <= 1'b1;
      cnt  <= '0;
    end else if (sync_p1 == line) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER - 1)) begin
      line <= sync_p1;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: filters the pins, frames bytes, folds E0/F0/E1
// prefixes into decoded make/break events and tracks the shift keys.
// The break flag is named key_release because "release" is a reserved word.
module ps2_scan_decoder
  import bk_kbd_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] incode,
  output logic       e0,
  output logic       key_release,
  output logic       shift,
  output logic       valid,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic clk_f;
  logic data_f;
  logic clk_f_prev;
  logic fall;

  frame_state_t state;
  frame_state_t state_next;

  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] timer;
  logic          pend_e0;
  logic          pend_rel;
  logic [2:0]    skip_cnt;
  logic          lshift;
  logic          rshift;

  logic tmo;
  logic byte_done;
  logic frame_ok;
  logic frame_err;

  ps2_line_filter #(.FILTER(FILTER)) u_clk_filter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw     (ps2_clk),
    .line    (clk_f)
  );

  ps2_line_filter #(.FILTER(FILTER)) u_data_filter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw     (ps2_data),
    .line    (data_f)
  );

  // Remember the previous filtered clock to detect its falling edge.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) clk_f_prev <= 1'b1;
    else       clk_f_prev <= clk_f;
  end

  assign fall      = clk_f_prev & ~clk_f;
  assign tmo       = (state != ST_IDLE) && !fall && (timer == '0);
  assign byte_done = (state == ST_STOP) && fall;
  assign frame_ok  = byte_done && data_f && (^{shreg, par_bit});
  assign frame_err = (byte_done && !frame_ok) || tmo;
  assign shift     = lshift | rshift;

  // Frame FSM state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Frame FSM next state: every bit advances on a filtered clock fall.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (fall && !data_f)              state_next = ST_DATA;
      ST_DATA:   if (fall && (bit_cnt == 3'd7))    state_next = ST_PARITY;
      ST_PARITY: if (fall)                         state_next = ST_STOP;
      ST_STOP:   if (fall)                         state_next = ST_IDLE;
      default:                                     state_next = ST_IDLE;
    endcase
    if (tmo) state_next = ST_IDLE;
  end

  // Serial payload capture; contents are meaningless until the stop bit.
  always_ff @(posedge clk_sys) begin
    if (fall && (state == ST_DATA))   shreg   <= {data_f, shreg[7:1]};
    if (fall && (state == ST_PARITY)) par_bit <= data_f;
  end

  // Bit counter, timeout timer, prefix handling, shift flags and pulses.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      timer       <= '0;
      pend_e0     <= 1'b0;
      pend_rel    <= 1'b0;
      skip_cnt    <= '0;
      lshift      <= 1'b0;
      rshift      <= 1'b0;
      incode      <= '0;
      e0          <= 1'b0;
      key_release <= 1'b0;
      valid       <= 1'b0;
      error       <= 1'b0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;

      if (state_next == ST_IDLE) timer <= '0;
      else if (fall)             timer <= TW'(TIMEOUT - 1);
      else if (timer != '0)      timer <= timer - 1'b1;

      if (fall && (state == ST_IDLE)) bit_cnt <= '0;
      else if (fall && (state == ST_DATA)) bit_cnt <= bit_cnt + 1'b1;

      if (frame_err) begin
        error    <= 1'b1;
        pend_e0  <= 1'b0;
        pend_rel <= 1'b0;
      end else if (frame_ok) begin
        if (skip_cnt != '0) begin
          skip_cnt <= skip_cnt - 1'b1;
        end else if (shreg == SC_E1) begin
          skip_cnt <= E1_SKIP;
        end else if (shreg == SC_E0) begin
          pend_e0 <= 1'b1;
        end else if (shreg == SC_F0) begin
          pend_rel <= 1'b1;
        end else begin
          incode      <= shreg;
          e0          <= pend_e0;
          key_release <= pend_rel;
          valid       <= 1'b1;
          pend_e0     <= 1'b0;
          pend_rel    <= 1'b0;
          if (!pend_e0 && (shreg == SC_LSHIFT)) lshift <= ~pend_rel;
          if (!pend_e0 && (shreg == SC_RSHIFT)) rshift <= ~pend_rel;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Randomized and directed bench for ps2_scan_decoder with a scancode-level
// reference model and a scoreboard of expected valid/error events.
module tb_ps2_scan_decoder;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 1500;
  localparam int HALF    = 25;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] incode;
  logic       e0;
  logic       key_release;
  logic       shift;
  logic       valid;
  logic       error;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
    logic       e0;
    logic       rel;
    logic       sh;
  } ev_t;

  ev_t exp_q[$];

  // reference model state
  logic m_pe0;
  logic m_prel;
  int   m_skip;
  logic m_ls;
  logic m_rs;

  ps2_scan_decoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .incode      (incode),
    .e0          (e0),
    .key_release (key_release),
    .shift       (shift),
    .valid       (valid),
    .error       (error)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic void model_reset();
    m_pe0 = 1'b0; m_prel = 1'b0; m_skip = 0; m_ls = 1'b0; m_rs = 1'b0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit ok);
    ev_t ev;
    ev = '0;
    if (!ok) begin
      ev.is_err = 1'b1;
      exp_q.push_back(ev);
      m_pe0 = 1'b0;
      m_prel = 1'b0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else if (b == 8'hE0) begin
      m_pe0 = 1'b1;
    end else if (b == 8'hF0) begin
      m_prel = 1'b1;
    end else begin
      if (!m_pe0 && b == 8'h12) m_ls = !m_prel;
      if (!m_pe0 && b == 8'h59) m_rs = !m_prel;
      ev.code = b;
      ev.e0   = m_pe0;
      ev.rel  = m_prel;
      ev.sh   = m_ls | m_rs;
      exp_q.push_back(ev);
      m_pe0 = 1'b0;
      m_prel = 1'b0;
    end
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // One PS/2 bit: data set while clock is high, then a low clock phase.
  task automatic send_bit(input logic v, input bit glitch);
    ps2_data = v;
    if (glitch) begin
      wait_cycles(10);
      ps2_clk = 1'b0;
      wait_cycles(FILTER / 2);
      ps2_clk = 1'b1;
      wait_cycles(HALF - 10 - FILTER / 2);
    end else begin
      wait_cycles(HALF);
    end
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 good with clock glitches
  task automatic send_frame(input logic [7:0] b, input int kind);
    logic par;
    model_frame(b, kind == 0 || kind == 3);
    par = ~^b;
    if (kind == 1) par = ~par;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], kind == 3 && (i == 2 || i == 5));
    send_bit(par, kind == 3);
    send_bit(kind == 2 ? 1'b0 : 1'b1, 1'b0);
    ps2_data = 1'b1;
    wait_cycles(2 * HALF);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i], 1'b0);
    ps2_data = 1'b1;
  endtask

  // Scoreboard: every valid/error pulse must match the next expected event.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk_sys);
      #1;
      if (valid || error) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'({valid, error}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err) begin
            chk("error_pulse", 32'({valid, error}), 32'b01);
          end else begin
            chk("valid_pulse", 32'({valid, error}), 32'b10);
            chk("incode", 32'(incode), 32'(e.code));
            chk("e0", 32'(e0), 32'(e.e0));
            chk("release", 32'(key_release), 32'(e.rel));
            chk("shift", 32'(shift), 32'(e.sh));
          end
        end
      end
    end
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1);
  end

  task automatic check_zero_outputs(input string pfx);
    chk({pfx, "_incode"}, 32'(incode), 32'd0);
    chk({pfx, "_e0"}, 32'(e0), 32'd0);
    chk({pfx, "_release"}, 32'(key_release), 32'd0);
    chk({pfx, "_shift"}, 32'(shift), 32'd0);
    chk({pfx, "_valid"}, 32'(valid), 32'd0);
    chk({pfx, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    int r;
    int kind;
    logic [7:0] b;
    model_reset();
    wait_cycles(5);
    #1;
    check_zero_outputs("reset");
    @(negedge clk_sys);
    reset = 1'b0;
    wait_cycles(20);

    // plain make/break
    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0); send_frame(8'h1C, 0);
    // extended key
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
    // shift tracking
    send_frame(8'h12, 0);
    send_frame(8'h59, 0);
    send_frame(8'hF0, 0); send_frame(8'h12, 0);
    send_frame(8'hF0, 0); send_frame(8'h59, 0);
    send_frame(8'hE0, 0); send_frame(8'h12, 0);
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h12, 0);
    // errors
    send_frame(8'h1C, 1);
    send_frame(8'h1C, 2);
    send_frame(8'hE0, 0); send_frame(8'h33, 1); send_frame(8'h6B, 0);

    // timeout mid-frame, then recovery
    model_frame(8'h00, 1'b0);
    send_partial(8'h55, 4);
    wait_cycles(TIMEOUT + 200);
    send_frame(8'h29, 0);

    // reset mid-frame clears outputs, prefixes and shift state
    send_frame(8'h12, 0);
    send_frame(8'hE0, 0);
    send_partial(8'h3C, 3);
    @(negedge clk_sys);
    reset = 1'b1;
    wait_cycles(3);
    #1;
    check_zero_outputs("midrst");
    @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
    wait_cycles(2 * HALF);
    send_frame(8'h1C, 0);

    // pause sequence swallowed
    send_frame(8'hE1, 0); send_frame(8'h14, 0); send_frame(8'h77, 0);
    send_frame(8'hE1, 0); send_frame(8'hF0, 0); send_frame(8'h14, 0);
    send_frame(8'hF0, 0); send_frame(8'h77, 0);
    send_frame(8'h1C, 0);

    // short clock glitches inside a frame are filtered away
    send_frame(8'h2A, 3);
    send_frame(8'h4D, 3);

    // randomized traffic
    for (int n = 0; n < 35; n++) begin
      r = $urandom_range(0, 19);
      case (r)
        0, 1, 2: b = 8'hE0;
        3, 4, 5: b = 8'hF0;
        6, 7:    b = 8'h12;
        8, 9:    b = 8'h59;
        10:      b = ($urandom_range(0, 2) == 0) ? 8'hE1 : 8'h1C;
        default: b = 8'($urandom_range(0, 255));
      endcase
      r = $urandom_range(0, 19);
      kind = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
      send_frame(b, kind);
    end

    wait_cycles(100);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
